jtag_dr_tx: RTL and testbench

//  Transmit side of the JTAGG ER1/ER2 debug data registers: SoC-to-host path driving JTDO1/JTDO2.
//  SoC hands over one word via valid/ready. The next host Capture-DR on the matching ER loads it.

---
 rtl/jtag_dr_tx_if.sv | 31 +++
 rtl/jtag_dr_tx.sv | 151 +++++++++++++++
 tb/tb_jtag_dr_tx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dr_tx_if.sv
// SoC-side word handover for the JTAG DR transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: producer holds tx_valid/tx_data/tx_sel until tx_ready; tx_done/busy report scan progress.
//
// Signals:
//   tx_data  WIDTH  word to send to the host
//   tx_sel   1      0 = ER1, 1 = ER2
//   tx_valid 1      word offered
//   tx_ready 1      hold register empty
//   tx_done  1      one-clk pulse when the host updated the scan carrying the word
//   busy     1      word captured into the DR, scan not yet updated
interface jtag_dr_tx_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_sel;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_done;
  logic             busy;

  modport master (
    output tx_data, tx_sel, tx_valid,
    input  tx_ready, tx_done, busy
  );

  modport slave (
    input  tx_data, tx_sel, tx_valid,
    output tx_ready, tx_done, busy
  );
endinterface

// File: rtl/jtag_dr_tx.sv
// Transmit side of the JTAGG ER1/ER2 data registers: one SoC word per host scan, shifted LSB first on JTDO1/JTDO2.
// Latency: JTCK edges act SYNC+1 clk cycles after the pin edge; TCK must be <= clk/8.
// Backpressure: tx_ready low while a word is held; the host capture on the matching ER frees the hold register.
//
// Ports: clk (clk48m, sole clock), rstn (async active-low), jtck/jshift/jce1/jce2/jupdate/jrstn from JTAGG,
//        tx (jtag_dr_tx_if.slave: tx_data, tx_sel, tx_valid, tx_ready, tx_done, busy), jtdo1/jtdo2 to JTAGG.
// Option: JTAG_TX_STATUS_EN makes the DR WIDTH+1 bits with bit0 = fresh flag (1 only when the capture took a word).
module jtag_dr_tx #(
  parameter int WIDTH = 32,
  parameter int SYNC  = 2   // synchronizer depth, must be >= 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jtck,
  input  logic        jshift,
  input  logic        jce1,
  input  logic        jce2,
  input  logic        jupdate,
  input  logic        jrstn,
  jtag_dr_tx_if.slave tx,
  output logic        jtdo1,
  output logic        jtdo2
);

`ifdef JTAG_TX_STATUS_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  // One extra stage on jtck gives the "old" value for edge detection.
  logic [SYNC:0]   tck_sr;
  logic [SYNC-1:0] shift_sr;
  logic [SYNC-1:0] ce1_sr;
  logic [SYNC-1:0] ce2_sr;
  logic [SYNC-1:0] upd_sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tck_sr   <= '0;
      shift_sr <= '0;
      ce1_sr   <= '0;
      ce2_sr   <= '0;
      upd_sr   <= '0;
    end else begin
      tck_sr   <= {tck_sr[SYNC-1:0], jtck};
      shift_sr <= {shift_sr[SYNC-2:0], jshift};
      ce1_sr   <= {ce1_sr[SYNC-2:0], jce1};
      ce2_sr   <= {ce2_sr[SYNC-2:0], jce2};
      upd_sr   <= {upd_sr[SYNC-2:0], jupdate};
    end
  end

  logic tck_rise;
  logic tck_fall;
  logic j_shift;
  logic j_ce;
  logic j_sel;
  logic j_upd;

  // Control inputs share the jtck pipeline depth, so they line up with the detected edge.
  assign tck_rise = tck_sr[SYNC-1] & ~tck_sr[SYNC];
  assign tck_fall = ~tck_sr[SYNC-1] & tck_sr[SYNC];
  assign j_shift  = shift_sr[SYNC-1];
  assign j_ce     = ce1_sr[SYNC-1] | ce2_sr[SYNC-1];
  assign j_sel    = ce2_sr[SYNC-1];
  assign j_upd    = upd_sr[SYNC-1];

  logic [WIDTH-1:0] hold;
  logic             hsel;
  logic             full;
  logic [DW-1:0]    shreg;
  logic [DW-1:0]    cap_word;
  logic             tdo_q;
  logic             capsel;
  logic             cap;
  logic             busy_q;
  logic             done_q;

`ifdef JTAG_TX_STATUS_EN
  assign cap_word = {hold, 1'b1};
`else
  assign cap_word = hold;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold   <= '0;
      hsel   <= 1'b0;
      full   <= 1'b0;
      shreg  <= '0;
      tdo_q  <= 1'b0;
      capsel <= 1'b0;
      cap    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Accept and consume never coincide: accept needs full=0, consume needs full=1.
      // A word offered on the same clk as a capture therefore waits for the next scan.
      if (tx.tx_valid && !full) begin
        hold <= tx.tx_data;
        hsel <= tx.tx_sel;
        full <= 1'b1;
      end

      if (!jrstn) begin
        // TAP reset drops an in-flight word; the hold register is left alone.
        shreg  <= '0;
        tdo_q  <= 1'b0;
        cap    <= 1'b0;
        busy_q <= 1'b0;
      end else if (tck_rise) begin
        if (j_ce && !j_shift) begin
          capsel <= j_sel;
          if (full && (hsel == j_sel)) begin
            shreg  <= cap_word;
            full   <= 1'b0;
            busy_q <= 1'b1;
            cap    <= 1'b1;
          end else begin
            shreg <= '0;
            cap   <= 1'b0;
          end
        end else if (j_ce && j_shift) begin
          shreg <= {1'b0, shreg[DW-1:1]};
        end

        if (j_upd) begin
          if (cap) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          cap <= 1'b0;
        end
      end else if (tck_fall) begin
        tdo_q <= shreg[0];
      end
    end
  end

  assign tx.tx_ready = ~full;
  assign tx.tx_done  = done_q;
  assign tx.busy     = busy_q;

  // Only the ER that was last captured sees data; the other output idles low.
  assign jtdo1 = tdo_q & ~capsel;
  assign jtdo2 = tdo_q & capsel;

endmodule

// File: tb/tb_jtag_dr_tx.sv
module tb_jtag_dr_tx;
  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
`ifdef JTAG_TX_STATUS_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic jtck, jshift, jce1, jce2, jupdate, jrstn;
  logic jtdo1, jtdo2;

  jtag_dr_tx_if #(.WIDTH(WIDTH)) txif ();

  jtag_dr_tx #(.WIDTH(WIDTH), .SYNC(SYNC)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .jtck    (jtck),
    .jshift  (jshift),
    .jce1    (jce1),
    .jce2    (jce2),
    .jupdate (jupdate),
    .jrstn   (jrstn),
    .tx      (txif.slave),
    .jtdo1   (jtdo1),
    .jtdo2   (jtdo2)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(negedge clk) if (txif.tx_done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Host-visible DR image of a word that was consumed by a capture.
  function automatic logic [63:0] dr_of(input logic [31:0] w);
`ifdef JTAG_TX_STATUS_EN
    return {31'b0, w, 1'b1};
`else
    return {32'b0, w};
`endif
  endfunction

  function automatic logic [63:0] mask_n(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // One TCK period: controls change while TCK is low, TDO is sampled just before the rise.
  // With inj set, a word is offered exactly in the clk where the DUT acts on this rise.
  task automatic tcyc(input bit c1, input bit c2, input bit sh, input bit up, input int half,
                      input bit inj, input logic [31:0] idat, output logic t1, output logic t2);
    jce1 = c1; jce2 = c2; jshift = sh; jupdate = up;
    repeat (half) @(negedge clk);
    t1 = jtdo1; t2 = jtdo2;
    jtck = 1'b1;
    for (int k = 0; k < half; k++) begin
      @(negedge clk);
      if (inj && k == SYNC - 1) begin
        txif.tx_data = idat; txif.tx_sel = 1'b0; txif.tx_valid = 1'b1;
      end
      if (inj && k == SYNC) txif.tx_valid = 1'b0;
    end
    jtck = 1'b0;
  endtask

  // Capture, n shifts, update, one idle TCK.
  task automatic scan(input bit er, input int n, input int half, input bit inj, input logic [31:0] idat,
                      output logic [63:0] rd, output bit oth);
    logic t1, t2;
    rd = '0; oth = 1'b0;
    tcyc(!er, er, 1'b0, 1'b0, half, inj, idat, t1, t2);
    for (int i = 0; i < n; i++) begin
      tcyc(!er, er, 1'b1, 1'b0, half, 1'b0, 32'h0, t1, t2);
      rd[i] = er ? t2 : t1;
      if ((er ? t1 : t2) !== 1'b0) oth = 1'b1;
    end
    tcyc(1'b0, 1'b0, 1'b0, 1'b1, half, 1'b0, 32'h0, t1, t2);
    if ((er ? t1 : t2) !== 1'b0) oth = 1'b1;
    tcyc(1'b0, 1'b0, 1'b0, 1'b0, half, 1'b0, 32'h0, t1, t2);
  endtask

  task automatic offer(input logic [31:0] d, input bit s);
    @(negedge clk);
    txif.tx_data = d; txif.tx_sel = s; txif.tx_valid = 1'b1;
    @(negedge clk);
    txif.tx_valid = 1'b0;
  endtask

  // Reference model of the hold register.
  bit          m_full = 1'b0;
  logic [31:0] m_word;
  bit          m_sel;

  task automatic moffer(input logic [31:0] d, input bit s);
    if (!m_full) begin m_full = 1'b1; m_word = d; m_sel = s; end
    offer(d, s);
  endtask

  typedef struct {
    bit          do_offer;
    logic [31:0] data;
    bit          sel;
    bit          er;
    int          n;
    int          half;
    logic [31:0] exp_word;
    bit          exp_fresh;
    int          exp_done;
    bit          exp_rdy_pre;
    bit          exp_rdy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [63:0] rd, exp;
    bit oth;
    logic t1, t2;
    int d0;

    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, DW, 25, 32'hDEADBEEF, 1'b1, 1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h12345678, 1'b1, 1'b0, DW,  4, 32'h0,       1'b0, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'hFFFF0000, 1'b0, 1'b1, DW,  4, 32'h12345678, 1'b1, 1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 1'b0, 40,  4, 32'h0,       1'b0, 0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 40,  4, 32'hA5A5A5A5, 1'b1, 1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h0F0F1234, 1'b1, 1'b1, 16,  4, 32'h0F0F1234, 1'b1, 1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 40,  4, 32'h0,       1'b0, 0, 1'b1, 1'b1};

    rstn = 1'b0; jtck = 1'b0; jshift = 1'b0; jce1 = 1'b0; jce2 = 1'b0; jupdate = 1'b0; jrstn = 1'b1;
    txif.tx_data = '0; txif.tx_sel = 1'b0; txif.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_jtdo1", 64'(jtdo1), 64'd0);
    chk("rst_jtdo2", 64'(jtdo2), 64'd0);
    chk("rst_tx_ready", 64'(txif.tx_ready), 64'd1);
    chk("rst_tx_done", 64'(txif.tx_done), 64'd0);
    chk("rst_busy", 64'(txif.busy), 64'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_tx_ready", 64'(txif.tx_ready), 64'd1);
    chk("post_rst_busy", 64'(txif.busy), 64'd0);
    chk("post_rst_jtdo1", 64'(jtdo1), 64'd0);

    // Directed scan table
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_offer) offer(vecs[v].data, vecs[v].sel);
      chk($sformatf("v%0d_ready_pre", v), 64'(txif.tx_ready), 64'(vecs[v].exp_rdy_pre));
      d0 = done_cnt;
      scan(vecs[v].er, vecs[v].n, vecs[v].half, 1'b0, 32'h0, rd, oth);
      exp = vecs[v].exp_fresh ? (dr_of(vecs[v].exp_word) & mask_n(vecs[v].n)) : 64'd0;
      chk($sformatf("v%0d_data", v), rd, exp);
      chk($sformatf("v%0d_other_er", v), 64'(oth), 64'd0);
      chk($sformatf("v%0d_done", v), 64'(done_cnt - d0), 64'(vecs[v].exp_done));
      chk($sformatf("v%0d_ready", v), 64'(txif.tx_ready), 64'(vecs[v].exp_rdy));
      chk($sformatf("v%0d_busy", v), 64'(txif.busy), 64'd0);
    end

    // TAP reset in the middle of a scan
    offer(32'hCAFEF00D, 1'b0);
    d0 = done_cnt;
    tcyc(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 32'h0, t1, t2);
    for (int i = 0; i < 10; i++) tcyc(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 32'h0, t1, t2);
    repeat (4) @(negedge clk);
    chk("jrst_busy_before", 64'(txif.busy), 64'd1);
    jrstn = 1'b0;
    repeat (3) @(negedge clk);
    jrstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("jrst_busy", 64'(txif.busy), 64'd0);
    chk("jrst_jtdo1", 64'(jtdo1), 64'd0);
    chk("jrst_jtdo2", 64'(jtdo2), 64'd0);
    tcyc(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 32'h0, t1, t2);
    tcyc(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 32'h0, t1, t2);
    chk("jrst_no_done", 64'(done_cnt - d0), 64'd0);
    scan(1'b0, DW, 4, 1'b0, 32'h0, rd, oth);
    chk("jrst_next_scan", rd, 64'd0);
    chk("jrst_next_done", 64'(done_cnt - d0), 64'd0);
    chk("jrst_ready", 64'(txif.tx_ready), 64'd1);
    offer(32'h5555AAAA, 1'b1);
    chk("jrst_accept", 64'(txif.tx_ready), 64'd0);
    scan(1'b1, DW, 4, 1'b0, 32'h0, rd, oth);
    chk("jrst_new_word", rd, dr_of(32'h5555AAAA));
    chk("jrst_new_done", 64'(done_cnt - d0), 64'd1);

    // Offer in the same clk as the capture: this scan is empty, the next carries it
    d0 = done_cnt;
    scan(1'b0, DW, 4, 1'b1, 32'h00000001, rd, oth);
    chk("race_scan1", rd, 64'd0);
    chk("race_ready", 64'(txif.tx_ready), 64'd0);
    chk("race_done1", 64'(done_cnt - d0), 64'd0);
    scan(1'b0, DW, 4, 1'b0, 32'h0, rd, oth);
    chk("race_scan2", rd, dr_of(32'h00000001));
    chk("race_done2", 64'(done_cnt - d0), 64'd1);

    // Randomized traffic against the hold-register model
    m_full = 1'b0;
    for (int it = 0; it < 16; it++) begin
      bit er; int n; bit hit;
      if (!m_full && $urandom_range(0, 3) != 0) moffer($urandom, 1'($urandom_range(0, 1)));
      else if (m_full && $urandom_range(0, 3) == 0) moffer($urandom, 1'($urandom_range(0, 1)));
      er = 1'($urandom_range(0, 1));
      n = $urandom_range(4, 40);
      hit = m_full && (m_sel == er);
      exp = hit ? (dr_of(m_word) & mask_n(n)) : 64'd0;
      if (hit) m_full = 1'b0;
      d0 = done_cnt;
      scan(er, n, 4, 1'b0, 32'h0, rd, oth);
      chk($sformatf("rnd%0d_data", it), rd, exp);
      chk($sformatf("rnd%0d_done", it), 64'(done_cnt - d0), 64'(hit));
      chk($sformatf("rnd%0d_ready", it), 64'(txif.tx_ready), 64'(!m_full));
      chk($sformatf("rnd%0d_other_er", it), 64'(oth), 64'd0);
    end

    // System reset mid-scan clears jtdo without a clock edge
    offer(32'hFFFFFFFF, 1'b0);
    tcyc(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 32'h0, t1, t2);
    repeat (4) @(negedge clk);
    chk("arst_tdo_before", 64'(jtdo1), 64'd1);
    #3 rstn = 1'b0;
    #1 chk("arst_jtdo1", 64'(jtdo1), 64'd0);
    chk("arst_busy", 64'(txif.busy), 64'd0);
    jce1 = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst_ready", 64'(txif.tx_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
